// File: rtl/user_cmd_pkg.sv
// Shared constants for the user-clock command engine: opcodes, FSM encoding,
// generator polynomial and register field positions.
package user_cmd_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_COUNT = 4'd1;
  localparam logic [3:0] OP_PRBS  = 4'd2;
  localparam logic [3:0] OP_CONST = 4'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int F_BUSY  = 0;
  localparam int F_DONE  = 1;
  localparam int F_ABORT = 2;
  localparam int F_ERR   = 3;

  localparam int C_TAG_LSB = 24;
  localparam int C_ABORT   = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/user_pattern_gen.sv
// Word generator: loads seed/step/mode, advances one word per strobe.
module user_pattern_gen
  import user_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [1:0]  mode,
  input  logic [31:0] seed,
  input  logic [31:0] step,
  output logic [31:0] word
);
  logic [31:0] step_r;
  logic [1:0]  mode_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word   <= '0;
      step_r <= '0;
      mode_r <= '0;
    end else if (load) begin
      // An all-zero LFSR would lock up, so PRBS substitutes 1 for a zero seed.
      word   <= (mode == OP_PRBS[1:0] && seed == '0) ? 32'd1 : seed;
      step_r <= step;
      mode_r <= mode;
    end else if (advance) begin
      case (mode_r)
        OP_COUNT[1:0]: word <= word + step_r;
        OP_PRBS[1:0]:  word <= (word >> 1) ^ (word[0] ? LFSR_POLY : 32'h0);
        default:       word <= word;
      endcase
    end
  end
endmodule

// File: rtl/user_cmd_engine.sv
// Tag-launched pattern command engine behind the AXI register bridge:
// reads eight control words, streams generated words, reports eight status words.
module user_cmd_engine
  import user_cmd_pkg::*;
#(
  parameter int          GAP_W   = 16,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] ctrl0,
  input  logic [31:0] ctrl1,
  input  logic [31:0] ctrl2,
  input  logic [31:0] ctrl3,
  input  logic [31:0] ctrl4,
  input  logic [31:0] ctrl5,
  input  logic [31:0] ctrl6,
  input  logic [31:0] ctrl7,
  output logic [31:0] stat0,
  output logic [31:0] stat1,
  output logic [31:0] stat2,
  output logic [31:0] stat3,
  output logic [31:0] stat4,
  output logic [31:0] stat5,
  output logic [31:0] stat6,
  output logic [31:0] stat7,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready
);
  logic [2:0]       state;
  logic [7:0]       tag_prev, run_tag, done_tag;
  logic             f_done, f_abort, f_err;
  logic [31:0]      n_r;
  logic [GAP_W-1:0] gap_r, gap_cnt;
  logic [31:0]      s1, s2, s3, s4, s5, s7;

  logic [7:0] tag;
  logic [3:0] op;
  logic       abort, hs, unused;

  assign tag     = ctrl0[C_TAG_LSB +: 8];
  assign abort   = ctrl0[C_ABORT];
  assign op      = ctrl0[3:0];
  assign m_valid = (state == ST_RUN);
  assign hs      = m_valid && m_ready;
  assign unused  = ^{ctrl0[23:9], ctrl0[7:4], ctrl4[31:GAP_W], ctrl5, ctrl6, ctrl7};

  user_pattern_gen u_gen (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .load    (state == ST_LOAD),
    .advance (hs),
    .mode    (op[1:0]),
    .seed    (ctrl2),
    .step    (ctrl3),
    .word    (m_data)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state    <= ST_IDLE;
      tag_prev <= '0;
      run_tag  <= '0;
      done_tag <= '0;
      f_done   <= 1'b0;
      f_abort  <= 1'b0;
      f_err    <= 1'b0;
      n_r      <= '0;
      gap_r    <= '0;
      gap_cnt  <= '0;
      s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0; s5 <= '0; s7 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tag != tag_prev) begin
            tag_prev <= tag;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          n_r     <= ctrl1;
          gap_r   <= ctrl4[GAP_W-1:0];
          run_tag <= tag_prev;
          f_done  <= 1'b0;
          f_abort <= 1'b0;
          f_err   <= (op > OP_CONST);
          s1 <= '0; s2 <= '0; s3 <= '0; s7 <= '0;
          if (op > OP_CONST || op == OP_NOP || ctrl1 == '0) state <= ST_DONE;
          else                                              state <= ST_RUN;
        end
        ST_RUN: begin
          s3 <= sat_inc(s3);
          if (!m_ready) s7 <= sat_inc(s7);
          if (hs) begin
            s1 <= s1 + 32'd1;
            s2 <= s2 ^ m_data;
            s4 <= m_data;
          end
          // Abort wins even mid-stall so a stuck consumer cannot hang the engine.
          if (abort) begin
            f_abort <= 1'b1;
            state   <= ST_DONE;
          end else if (hs) begin
            if (s1 + 32'd1 == n_r) state <= ST_DONE;
            else if (gap_r != '0) begin
              gap_cnt <= gap_r;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          s3 <= sat_inc(s3);
          if (abort) begin
            f_abort <= 1'b1;
            state   <= ST_DONE;
          end else if (gap_cnt == GAP_W'(1)) state <= ST_RUN;
          else                               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        ST_DONE: begin
          f_done   <= 1'b1;
          done_tag <= run_tag;
          s5       <= s5 + 32'd1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stat0          = {done_tag, run_tag, 16'h0};
    stat0[F_BUSY]  = (state != ST_IDLE);
    stat0[F_DONE]  = f_done;
    stat0[F_ABORT] = f_abort;
    stat0[F_ERR]   = f_err;
  end

  assign stat1 = s1;
  assign stat2 = s2;
  assign stat3 = s3;
  assign stat4 = s4;
  assign stat5 = s5;
  assign stat6 = VERSION;
  assign stat7 = s7;
endmodule

// File: tb/tb_user_cmd_engine.sv
// Self-checking bench: transaction-level model predicts words, valid timing and
// status; a negedge monitor compares every cycle, directed tests pin literals.
module tb_user_cmd_engine;
  localparam logic [31:0] VER  = 32'h0001_0000;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic [31:0] ctrl0, ctrl1, ctrl2, ctrl3, ctrl4, ctrl5, ctrl6, ctrl7;
  logic [31:0] stat [0:7];
  logic [31:0] m_data;
  logic        m_valid, m_ready;

  always #5 user_clk = ~user_clk;

  user_cmd_engine dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n),
    .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3),
    .ctrl4(ctrl4), .ctrl5(ctrl5), .ctrl6(ctrl6), .ctrl7(ctrl7),
    .stat0(stat[0]), .stat1(stat[1]), .stat2(stat[2]), .stat3(stat[3]),
    .stat4(stat[4]), .stat5(stat[5]), .stat6(stat[6]), .stat7(stat[7]),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q[$];
  bit          mon_en = 0, launch_req = 0, ev, running;
  int          cyc = 0, start = 0, avail = 0, vbase = 0, cur_gap = 0;
  int          hs_cnt = 0, stalls = 0, rdy_mode = 0;
  logic [31:0] m_cnt = 0, m_xor = 0, m_last = 0, m_run = 0, m_stall = 0, m_done = 0;
  bit          m_err = 0, m_aborted = 0;
  logic [31:0] wlog [0:15];
  bit          hist [0:63];
  logic [7:0]  cur_tag = 0;

  always @(negedge user_clk) begin
    if (mon_en) begin
      cyc++;
      if (launch_req) begin
        launch_req = 0;
        start = cyc + 2;
        avail = cyc + 2;
        vbase = cyc;
      end
      ev      = (exp_q.size() > 0) && (cyc >= avail);
      running = (exp_q.size() > 0) && (cyc >= start);
      if (cyc - vbase < 64) hist[cyc - vbase] = m_valid;
      chk("m_valid", 32'(m_valid), 32'(ev));
      if (ev) chk("m_data", m_data, exp_q[0]);
      if (running) m_run++;
      if (ev && m_ready) begin
        m_cnt++;
        m_xor  = m_xor ^ exp_q[0];
        m_last = exp_q[0];
        if (hs_cnt < 16) wlog[hs_cnt] = m_data;
        hs_cnt++;
        void'(exp_q.pop_front());
        avail = cyc + 1 + cur_gap;
      end else if (ev) m_stall++;
      if (running && ctrl0[8]) begin
        exp_q.delete();
        m_aborted = 1;
      end
    end
  end

  always @(posedge user_clk) begin
    #1;
    case (rdy_mode)
      1: m_ready = ($urandom_range(0, 3) != 0);
      2: if (hs_cnt == 1 && stalls < 3) begin m_ready = 1'b0; stalls++; end
         else m_ready = 1'b1;
      3: m_ready = (hs_cnt < 10);
      default: m_ready = 1'b1;
    endcase
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] n, input logic [31:0] seed,
                        input logic [31:0] step, input int gap);
    logic [31:0] x;
    @(posedge user_clk); #1;
    cur_tag = (cur_tag == 8'hFF) ? 8'h01 : cur_tag + 8'h01;
    ctrl1 = n; ctrl2 = seed; ctrl3 = step; ctrl4 = 32'(gap);
    ctrl0 = {cur_tag, 15'h0, 1'b0, 4'h0, op};
    cur_gap = gap; m_err = (op > 4'd3); m_aborted = 0;
    m_cnt = 0; m_xor = 0; m_run = 0; m_stall = 0; m_done++;
    hs_cnt = 0; stalls = 0;
    exp_q.delete();
    if (op >= 4'd1 && op <= 4'd3) begin
      x = (op == 4'd2 && seed == 0) ? 32'd1 : seed;
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back(x);
        if (op == 4'd1) x = x + step;
        else if (op == 4'd2) x = (x >> 1) ^ (x[0] ? POLY : 32'h0);
      end
    end
    launch_req = 1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(stat[0][1] && stat[0][31:24] == cur_tag) && k < 3000) begin
      @(negedge user_clk);
      k++;
    end
    #1;
    chk("done_wait", 32'(k < 3000), 32'd1);
  endtask

  task automatic end_chk();
    chk("stat0", stat[0], {cur_tag, cur_tag, 12'h0, m_err, m_aborted, 1'b1, 1'b0});
    chk("stat1", stat[1], m_cnt);
    chk("stat2", stat[2], m_xor);
    chk("stat3", stat[3], m_run);
    chk("stat4", stat[4], m_last);
    chk("stat5", stat[5], m_done);
    chk("stat6", stat[6], VER);
    chk("stat7", stat[7], m_stall);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tmp;
    user_rst_n = 1'b0; m_ready = 1'b1;
    ctrl0 = 0; ctrl1 = 0; ctrl2 = 0; ctrl3 = 0; ctrl4 = 0;
    ctrl5 = 32'hDEAD_BEEF; ctrl6 = 32'h1234_5678; ctrl7 = 32'hFFFF_FFFF;
    repeat (3) @(negedge user_clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_stat%0d", i), stat[i], (i == 6) ? VER : 32'd0);
    @(posedge user_clk); #1;
    user_rst_n = 1'b1;
    mon_en = 1;
    repeat (3) @(negedge user_clk);
    chk("idle_no_launch", stat[0], 32'd0);

    // COUNT seed 5 step 3 N 4
    rdy_mode = 0;
    launch(4'd1, 32'd4, 32'd5, 32'd3, 0);
    wait_done();
    end_chk();
    chk("cnt_w0", wlog[0], 32'd5);
    chk("cnt_w1", wlog[1], 32'd8);
    chk("cnt_w2", wlog[2], 32'd11);
    chk("cnt_w3", wlog[3], 32'd14);
    chk("cnt_stat1", stat[1], 32'd4);
    chk("cnt_stat2", stat[2], 32'h8);
    chk("cnt_stat4", stat[4], 32'd14);
    chk("cnt_tag", 32'(stat[0][31:24]), 32'h01);
    chk("cnt_done", 32'(stat[0][1]), 32'd1);
    chk("cnt_stat5", stat[5], 32'd1);

    // PRBS with three stall cycles on word 2
    rdy_mode = 2;
    launch(4'd2, 32'd3, 32'd1, 32'd0, 0);
    wait_done();
    end_chk();
    chk("prbs_w0", wlog[0], 32'h0000_0001);
    chk("prbs_w1", wlog[1], 32'h8020_0003);
    chk("prbs_w2", wlog[2], 32'hC030_0002);
    chk("prbs_stat7", stat[7], 32'd3);

    // Gap pattern
    rdy_mode = 0;
    launch(4'd1, 32'd3, 32'd100, 32'd1, 2);
    wait_done();
    end_chk();
    tmp = 0;
    for (int i = 0; i < 7; i++) tmp = {tmp[30:0], hist[2 + i]};
    chk("gap_pattern", tmp, 32'b1001001);
    chk("gap_stat3", stat[3], 32'd7);

    // N = 0
    launch(4'd1, 32'd0, 32'd1, 32'd1, 0);
    repeat (3) @(negedge user_clk);
    #1 chk("n0_done_early", 32'(stat[0][1]), 32'd0);
    @(negedge user_clk);
    #1 chk("n0_done", 32'(stat[0][1]), 32'd1);
    wait_done();
    end_chk();

    // Illegal opcode
    launch(4'd7, 32'd5, 32'd1, 32'd1, 0);
    wait_done();
    end_chk();
    chk("op7_err", 32'(stat[0][3]), 32'd1);
    chk("op7_stat1", stat[1], 32'd0);

    // Same tag rewrite never relaunches
    @(posedge user_clk); #1;
    ctrl0 = {cur_tag, 15'h0, 1'b0, 4'h0, 4'd1};
    repeat (10) @(negedge user_clk);
    #1 chk("same_tag_stat5", stat[5], m_done);
    chk("same_tag_idle", 32'(stat[0][0]), 32'd0);

    // Abort after 10 handshakes with consumer stalled
    rdy_mode = 3;
    launch(4'd1, 32'd100, 32'd0, 32'd1, 0);
    begin
      int k = 0;
      while (hs_cnt < 10 && k < 1000) begin @(posedge user_clk); #1; k++; end
      chk("abort_wait", 32'(k < 1000), 32'd1);
    end
    ctrl0[8] = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    #1 chk("abort_valid_low", 32'(m_valid), 32'd0);
    wait_done();
    end_chk();
    chk("abort_flag", 32'(stat[0][2]), 32'd1);
    chk("abort_stat1", stat[1], 32'd10);
    @(posedge user_clk); #1;
    ctrl0[8] = 1'b0;
    rdy_mode = 0;

    // Reset mid-RUN, then relaunch of the same (nonzero) tag
    launch(4'd1, 32'd50, 32'd7, 32'd2, 0);
    begin
      int k = 0;
      while (hs_cnt < 5 && k < 1000) begin @(posedge user_clk); #1; k++; end
    end
    user_rst_n = 1'b0;
    mon_en = 0;
    exp_q.delete();
    m_cnt = 0; m_xor = 0; m_last = 0; m_run = 0; m_stall = 0; m_done = 0;
    @(negedge user_clk);
    #1 chk("mrst_m_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("mrst_stat%0d", i), stat[i], (i == 6) ? VER : 32'd0);
    @(posedge user_clk); #1;
    begin
      logic [31:0] x;
      x = 32'd7;
      for (int i = 0; i < 50; i++) begin exp_q.push_back(x); x = x + 32'd2; end
    end
    m_err = 0; m_aborted = 0; m_done = 1; hs_cnt = 0;
    launch_req = 1;
    mon_en = 1;
    user_rst_n = 1'b1;
    wait_done();
    end_chk();

    // Randomized commands
    rdy_mode = 1;
    for (int t = 0; t < 16; t++) begin
      logic [3:0]  op;
      int          r;
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(1, 3));
      launch(op, 32'($urandom_range(0, 20)),
             ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
             32'($urandom), $urandom_range(0, 3));
      wait_done();
      end_chk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
